// File: rtl/wb_stage.sv
// Write-back stage: retires ALU/CSR results in one cycle and waits on the LSU for loads,
// formatting the returned lane, with timeout and flush handling for the outstanding load.
module wb_stage #(
    parameter int TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        wb_ready_o,
    input  logic        ex_rf_we_i,
    input  logic [4:0]  ex_rf_waddr_i,
    input  logic [31:0] ex_rf_wdata_i,
    input  logic        ex_is_load_i,
    input  logic [1:0]  ex_load_type_i,
    input  logic        ex_load_sext_i,
    input  logic [1:0]  ex_addr_lsb_i,
    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_err_i,
    input  logic        flush_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        load_pending_o,
    output logic [4:0]  pending_waddr_o,
    output logic        load_err_o,
    output logic        instr_done_o
);

    localparam int CNT_W = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        ld_rd_q;
    logic [1:0]        ld_type_q;
    logic [1:0]        ld_lsb_q;
    logic              ld_sext_q;

    logic              accept;
    logic              timeout_hit;
    logic              we_d;
    logic              err_d;
    logic              done_d;
    logic [4:0]        waddr_d;
    logic [31:0]       wdata_d;

    // Selects the addressed byte/half lane and extends it; reserved type behaves as word.
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [1:0]  ltype,
                                                input logic        sext,
                                                input logic [1:0]  lsb);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = rdata[{lsb, 3'b000} +: 8];
        h = lsb[1] ? rdata[31:16] : rdata[15:0];
        case (ltype)
            2'b00:   r = sext ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   r = sext ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign accept      = ex_valid_i && wb_ready_o && !flush_i;
    assign timeout_hit = (cnt_q == CNT_W'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && ex_is_load_i) state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                // A flush only needs to wait out the bus if the response has not come yet.
                if (flush_i)           state_d = lsu_rvalid_i ? IDLE : DRAIN;
                else if (lsu_rvalid_i) state_d = IDLE;
                else if (timeout_hit)  state_d = DRAIN;
            end
            DRAIN: begin
                if (lsu_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_ready_o      = (state_q == IDLE);
        load_pending_o  = (state_q != IDLE) && (ld_rd_q != 5'd0);
        pending_waddr_o = (state_q != IDLE) ? ld_rd_q : 5'd0;
        we_d            = 1'b0;
        err_d           = 1'b0;
        done_d          = 1'b0;
        waddr_d         = ld_rd_q;
        wdata_d         = format_load(lsu_rdata_i, ld_type_q, ld_sext_q, ld_lsb_q);
        case (state_q)
            IDLE: begin
                if (accept && !ex_is_load_i) begin
                    done_d  = 1'b1;
                    we_d    = ex_rf_we_i && (ex_rf_waddr_i != 5'd0);
                    waddr_d = ex_rf_waddr_i;
                    wdata_d = ex_rf_wdata_i;
                end
            end
            WAIT_LOAD: begin
                if (!flush_i) begin
                    if (lsu_rvalid_i) begin
                        done_d = 1'b1;
                        err_d  = lsu_err_i;
                        we_d   = !lsu_err_i && (ld_rd_q != 5'd0);
                    end else if (timeout_hit) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---- capture of the load being accepted ----
    always_ff @(posedge clk_i) begin
        if (accept && ex_is_load_i) begin
            ld_rd_q   <= ex_rf_waddr_i;
            ld_type_q <= ex_load_type_i;
            ld_sext_q <= ex_load_sext_i;
            ld_lsb_q  <= ex_addr_lsb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_LOAD && !lsu_rvalid_i && !flush_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---- write-back outputs; address/data only move on an actual write ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o      <= 1'b0;
            load_err_o   <= 1'b0;
            instr_done_o <= 1'b0;
            rf_waddr_o   <= 5'd0;
            rf_wdata_o   <= 32'd0;
        end else begin
            rf_we_o      <= we_d;
            load_err_o   <= err_d;
            instr_done_o <= done_d;
            if (we_d) begin
                rf_waddr_o <= waddr_d;
                rf_wdata_o <= wdata_d;
            end
        end
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, meaning max cycles waiting for an LSU response before a load error is declared (range 1..1023).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX result valid this cycle
- wb_ready_o  out  1  stage can accept an EX result
- ex_rf_we_i  in  1  instruction writes regfile
- ex_rf_waddr_i  in  5  destination register
- ex_rf_wdata_i  in  32  EX/CSR result
- ex_is_load_i  in  1  instruction is a load
- ex_load_type_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ex_load_sext_i  in  1  sign-extend load data
- ex_addr_lsb_i  in  2  low bits of the load address
- lsu_rvalid_i  in  1  LSU read response valid
- lsu_rdata_i  in  32  LSU read data
- lsu_err_i  in  1  LSU bus error, qualified by lsu_rvalid_i
- flush_i  in  1  kill the in-flight load and any same-cycle accept
- rf_we_o  out  1  regfile write enable
- rf_waddr_o  out  5  regfile write address
- rf_wdata_o  out  32  regfile write data
- load_pending_o  out  1  load outstanding with non-zero rd
- pending_waddr_o  out  5  rd of the outstanding load
- load_err_o  out  1  one-cycle pulse on a load bus error or timeout
- instr_done_o  out  1  one-cycle pulse when an instruction retires from WB

Function
REQ-004 SHALL implement FSM states IDLE, WAIT_LOAD and DRAIN; wb_ready_o SHALL be 1 only in IDLE.
REQ-005 SHALL treat "accept" as ex_valid_i && wb_ready_o && !flush_i; with flush_i high, no accept occurs.
REQ-006 On accept of a non-load, SHALL drive the following cycle:
- rf_we_o = ex_rf_we_i && (ex_rf_waddr_i != 0)
- rf_waddr_o and rf_wdata_o = the captured values
- instr_done_o = 1
- state remains IDLE (latency 1 cycle, throughput 1 per cycle)
REQ-007 On accept of a load, SHALL capture rd, type, sext and lsb, clear the timeout counter, and enter WAIT_LOAD.
REQ-008 In WAIT_LOAD with lsu_rvalid_i=1 and lsu_err_i=0, the next cycle SHALL drive:
- rf_we_o = (rd != 0)
- rf_wdata_o = formatted data
- instr_done_o = 1
- state returns to IDLE
REQ-009 Load formatting SHALL be:
- byte: lane = lsu_rdata_i[8*lsb +: 8]
- half: lane = lsb[1] ? [31:16] : [15:0]
- word: all 32 bits, lsb ignored
- the lane SHALL be zero- or sign-extended to 32 bits per sext
REQ-010 In WAIT_LOAD, lsu_rvalid_i with lsu_err_i=1 SHALL produce, next cycle: no write, load_err_o=1, instr_done_o=1, state IDLE.
REQ-011 In WAIT_LOAD, the timeout counter SHALL increment each cycle without lsu_rvalid_i. When it reaches TimeoutCycles, the next cycle SHALL give load_err_o=1, no write, instr_done_o=0, state DRAIN.
REQ-012 flush_i in WAIT_LOAD without lsu_rvalid_i SHALL move the FSM to DRAIN with no write and no pulses.
REQ-013 In DRAIN, SHALL discard the first lsu_rvalid_i, data or error, then return to IDLE; no output pulses from DRAIN.
REQ-014 A response arriving together with flush_i in WAIT_LOAD SHALL be discarded and the FSM SHALL go to IDLE.
REQ-015 lsu_rvalid_i in IDLE SHALL be ignored.
REQ-016 load_pending_o SHALL be 1 in WAIT_LOAD or DRAIN when the captured rd != 0. pending_waddr_o SHALL show the captured rd in those states and 0 otherwise.
REQ-017 rf_we_o, load_err_o and instr_done_o SHALL be registered single-cycle pulses. rf_waddr_o and rf_wdata_o SHALL hold their last value when rf_we_o=0.

Reset
REQ-018 While rst_i=1 at a clock edge:
- state = IDLE and timeout counter = 0
- rf_we_o, load_err_o, instr_done_o and load_pending_o = 0
- rf_waddr_o = 0, rf_wdata_o = 0, pending_waddr_o = 0
REQ-019 Reset during WAIT_LOAD or DRAIN SHALL abandon the load; the first cycle after reset SHALL show wb_ready_o=1.

Verification
REQ-020 ALU op: ex_valid_i=1, we=1, rd=5, wdata=0x1234 -> next cycle rf_we_o=1, waddr=5, wdata=0x00001234, instr_done_o=1.
REQ-021 Signed byte load: rd=7, type=00, sext=1, lsb=2; lsu_rdata_i=0x00800000 three cycles later -> wb_ready_o=0 and load_pending_o=1 while waiting, then rf_wdata_o=0xFFFFFF80, rf_we_o=1.
REQ-022 Half load with rd=0: lsb=2, sext=0, lsu_rdata_i=0xBEEF0000 -> rf_we_o=0, instr_done_o=1, load_pending_o=0 throughout.
REQ-023 Timeout: TimeoutCycles=4 and no rvalid -> load_err_o pulses once, state DRAIN; a later rvalid=1 -> no write, then wb_ready_o=1.
REQ-024 Flush, then response: flush_i while in WAIT_LOAD, then rvalid with data 0xCAFEF00D -> no write, no pulses, IDLE after the response.
REQ-025 Back-to-back: ALU ops to rd 1, 2, 3 on consecutive cycles -> three consecutive rf_we_o pulses in order; rst_i asserted in the middle -> outputs zero the next cycle.
